// File: rtl/vga_frame_reader_pkg.sv
// Shared types and constants for the VGA framebuffer reader.
//   state_t     : reader FSM states (IDLE, FETCH, DRAIN)
//   pix_entry_t : one pixel as it travels through the FIFO (data + frame tags)
//   ADDR_W      : word-address width of the framebuffer RAM
package vga_frame_reader_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eol;
    logic              eof;
  } pix_entry_t;

endpackage

// File: rtl/vga_frame_reader_if.sv
// Bus bundle for the frame reader: the Avalon-MM read port towards the
// framebuffer RAM plus the outgoing pixel stream.
//   master : the frame reader (drives address/chipselect, pixel stream)
//   slave  : RAM + downstream sink (drives readdata, pix_ready)
//
// Pixel stream handshake: a pixel transfers in every cycle where
// pix_valid && pix_ready. Once pix_valid is high it stays high, and
// pix_data/pix_sop/pix_eol/pix_eof stay constant, until that transfer
// happens (the only exception is an abort, which withdraws the stream).
// pix_valid never depends combinationally on pix_ready.
interface vga_frame_reader_if;
  import vga_frame_reader_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write;
  logic [1:0]        byteenable;
  logic              clken;
  logic [DATA_W-1:0] readdata;

  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sop;
  logic              pix_eol;
  logic              pix_eof;

  modport master (
    output address, chipselect, write, byteenable, clken,
    input  readdata,
    output pix_data, pix_valid, pix_sop, pix_eol, pix_eof,
    input  pix_ready
  );

  modport slave (
    input  address, chipselect, write, byteenable, clken,
    output readdata,
    input  pix_data, pix_valid, pix_sop, pix_eol, pix_eof,
    output pix_ready
  );

endinterface

// File: rtl/vga_pix_fifo.sv
// Pixel FIFO with a registered show-ahead output stage.
//   clk, rst_n  : clock, async active-low reset
//   flush       : drop every entry (synchronous)
//   push        : write push_entry this cycle
//   pop         : head consumed this cycle (only meaningful with out_valid)
//   out_valid   : out_entry holds the head entry
//   count       : entries held, including the output register
// The output register is refilled from the storage ring, or straight from
// the push port when the ring is empty, so a push into an empty FIFO is
// visible on out_valid the very next cycle.
module vga_pix_fifo
  import vga_frame_reader_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  pix_entry_t             push_entry,
  input  logic                   pop,
  output logic                   out_valid,
  output pix_entry_t             out_entry,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  pix_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   mem_cnt;
  logic          load_out;
  logic          mem_rd;
  logic          mem_wr;
  logic          bypass;

  always_comb begin
    load_out = !out_valid || pop;
    mem_rd   = load_out && (mem_cnt != '0);
    bypass   = load_out && (mem_cnt == '0) && push;
    mem_wr   = push && !bypass;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      out_entry <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      out_entry <= '0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
      if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
      mem_cnt <= mem_cnt + {{PW{1'b0}}, mem_wr} - {{PW{1'b0}}, mem_rd};
      if (mem_rd) begin
        out_entry <= mem[rd_ptr];
        out_valid <= 1'b1;
      end else if (bypass) begin
        out_entry <= push_entry;
        out_valid <= 1'b1;
      end else if (load_out) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr && !flush) mem[wr_ptr] <= push_entry;
  end

  assign count = mem_cnt + {{PW{1'b0}}, out_valid};

endmodule

// File: rtl/vga_frame_reader.sv
// Avalon-MM read master that scans a framebuffer in raster order and emits
// it as a tagged valid/ready pixel stream.
//   clk, reset_n : clock, async active-low reset
//   start        : pulse, begins one frame when idle
//   continuous   : chain the next frame automatically after frame_done
//   abort        : pulse, kills the current frame and flushes the FIFO
//   busy         : high while not IDLE
//   frame_done   : one-cycle pulse the cycle after the eof pixel transfers
//   state_dbg    : current FSM state
//   bus          : RAM read port + pixel stream (master side)
// Reads are credit-limited: a read issues only if FIFO occupancy plus the
// read still in flight leaves room for its data, so the FIFO never overflows
// however long the sink stalls.
module vga_frame_reader
  import vga_frame_reader_pkg::*;
#(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               continuous,
  input  logic               abort,
  output logic               busy,
  output logic               frame_done,
  output state_t             state_dbg,
  vga_frame_reader_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [CW+1:0]     DEPTH_L   = (CW + 2)'(FIFO_DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] line;
  logic              issue;
  logic              abort_act;
  logic              frame_start;
  logic              eof_hs;
  logic              pop;
  logic [CW+1:0]     occ;

  // Read in flight: readdata for it arrives next cycle; tags ride alongside.
  logic              infl_vld;
  logic              infl_sop;
  logic              infl_eol;
  logic              infl_eof;

  pix_entry_t        push_entry;
  pix_entry_t        out_entry;
  logic              out_valid;
  logic [CW:0]       fifo_count;

  assign abort_act = abort && (state != IDLE);
  assign pop       = out_valid && bus.pix_ready;
  assign eof_hs    = pop && out_entry.eof;
  assign occ       = {1'b0, fifo_count} + {{(CW + 1){1'b0}}, infl_vld};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; abort outranks start and the eof handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start && !abort) state_nxt = FETCH;
      FETCH: begin
        if (abort)                              state_nxt = IDLE;
        else if (issue && (rd_idx == LAST_IDX)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort)       state_nxt = IDLE;
        else if (eof_hs) state_nxt = continuous ? FETCH : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    frame_start = (state_nxt == FETCH) && (state != FETCH);
  end

  // Output logic
  always_comb begin
    busy           = (state != IDLE);
    issue          = (state == FETCH) && (occ < DEPTH_L);
    bus.chipselect = issue;
    bus.address    = issue ? (BASE + rd_idx) : '0;
  end

  // Read index and raster counters advance once per issued read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_idx <= '0;
      col    <= '0;
      line   <= '0;
    end else if (frame_start) begin
      rd_idx <= '0;
      col    <= '0;
      line   <= '0;
    end else if (issue) begin
      rd_idx <= rd_idx + 1'b1;
      if (col == COL_LAST) begin
        col  <= '0;
        line <= line + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // A read issued in the abort cycle is dropped before it reaches the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      infl_vld <= 1'b0;
      infl_sop <= 1'b0;
      infl_eol <= 1'b0;
      infl_eof <= 1'b0;
    end else begin
      infl_vld <= issue && !abort_act;
      infl_sop <= (rd_idx == '0);
      infl_eol <= (col == COL_LAST);
      infl_eof <= (col == COL_LAST) && (line == LINE_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_done <= 1'b0;
    else          frame_done <= (state == DRAIN) && eof_hs && !abort;
  end

  assign push_entry = '{data: bus.readdata, sop: infl_sop, eol: infl_eol, eof: infl_eof};

  vga_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (reset_n),
    .flush      (abort_act),
    .push       (infl_vld && !abort_act),
    .push_entry (push_entry),
    .pop        (pop),
    .out_valid  (out_valid),
    .out_entry  (out_entry),
    .count      (fifo_count)
  );

  assign bus.write      = 1'b0;
  assign bus.byteenable = 2'b11;
  assign bus.clken      = 1'b1;
  assign bus.pix_data   = out_entry.data;
  assign bus.pix_valid  = out_valid;
  assign bus.pix_sop    = out_entry.sop;
  assign bus.pix_eol    = out_entry.eol;
  assign bus.pix_eof    = out_entry.eof;
  assign state_dbg      = state;

endmodule
